// File: rtl/aurora_tx_frame_buffer.sv
// Store-and-forward TX frame buffer.
// Accepts 32-bit words from the readout framer, which cannot be stalled. Only
// complete frames are committed, and each committed frame is replayed as an
// AXI4-Stream burst once the Aurora link is up. A frame that does not fit is
// dropped whole, and the drop is recorded in a sticky flag and a saturating
// counter.

module aurora_tx_frame_buffer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Upstream framer side (no backpressure)
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [3:0]        in_keep,
    // Aurora TX user interface
    input  logic              channel_up,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic [3:0]        m_tkeep,
    input  logic              m_tready,
    // Status
    output logic [ADDR_W:0]   frames_pending,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    localparam int DEPTH = 1 << ADDR_W;

    // Pointers carry one extra wrap bit, so that full and empty can be told apart.
    typedef logic [ADDR_W:0]   ptr_t;
    typedef logic [ADDR_W-1:0] idx_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_SEND
    } r_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem_data [DEPTH];
    logic [3:0]  mem_keep [DEPTH];
    logic        mem_last [DEPTH];

    // ------------------------------------------------------------------
    // Pointers and state
    // ------------------------------------------------------------------
    ptr_t     wr_ptr, wr_ptr_next;
    ptr_t     frm_start, frm_start_next;
    ptr_t     commit_ptr, commit_ptr_next;
    ptr_t     rd_ptr, rd_ptr_next;
    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    ptr_t     occupancy;
    logic     full;
    ptr_t     wr_prev;
    idx_t     wr_idx;
    idx_t     prev_idx;
    idx_t     rd_idx;

    // Write-side strobes decoded by the write FSM
    logic     mem_we;
    logic     set_last;
    logic     commit;
    logic     drop;

    // Read-side strobes decoded by the read FSM
    logic     send_active;
    logic     handshake;
    logic     read_last;

    // Full is judged on the pointers as they stand before the edge, so a word
    // leaving in the same cycle does not free room for an incoming word.
    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == ptr_t'(DEPTH));
    assign wr_prev   = wr_ptr - ptr_t'(1);
    assign wr_idx    = wr_ptr[ADDR_W-1:0];
    assign prev_idx  = wr_prev[ADDR_W-1:0];
    assign rd_idx    = rd_ptr[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Write FSM: next-state and write strobes
    // ------------------------------------------------------------------
    // Decide where each incoming word goes and when a frame commits or drops.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        w_state_next    = w_state;
        wr_ptr_next     = wr_ptr;
        frm_start_next  = frm_start;
        commit_ptr_next = commit_ptr;
        mem_we          = 1'b0;
        set_last        = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;

        unique case (w_state)
            W_IDLE, W_FILL: begin
                if (in_valid) begin
                    if (!full) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr + ptr_t'(1);
                        if (in_last) begin
                            commit          = 1'b1;
                            frm_start_next  = wr_ptr + ptr_t'(1);
                            commit_ptr_next = wr_ptr + ptr_t'(1);
                            w_state_next    = W_IDLE;
                        end else begin
                            w_state_next    = W_FILL;
                        end
                    end else begin
                        // No room: roll back to the frame start and discard the rest.
                        drop         = 1'b1;
                        wr_ptr_next  = frm_start;
                        w_state_next = in_last ? W_IDLE : W_DROP;
                    end
                end else if (in_last && (w_state == W_FILL)) begin
                    // A bare end strobe closes the frame on the word already stored.
                    set_last        = 1'b1;
                    commit          = 1'b1;
                    frm_start_next  = wr_ptr;
                    commit_ptr_next = wr_ptr;
                    w_state_next    = W_IDLE;
                end
                // A bare end strobe in W_IDLE is an empty frame and is ignored.
            end

            W_DROP: begin
                if (in_last) begin
                    w_state_next = W_IDLE;
                end
            end

            default: begin
                w_state_next = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM: next-state and handshake decode
    // ------------------------------------------------------------------
    // Start a burst when a committed frame exists and the link is up, then stream it out.
    always_comb begin
        r_state_next = r_state;
        rd_ptr_next  = rd_ptr;
        send_active  = 1'b0;
        handshake    = 1'b0;
        read_last    = 1'b0;

        unique case (r_state)
            R_IDLE: begin
                // The link state matters only here; a started frame always completes.
                if (channel_up && (rd_ptr != commit_ptr)) begin
                    r_state_next = R_SEND;
                end
            end

            R_SEND: begin
                send_active = 1'b1;
                if (m_tready) begin
                    handshake   = 1'b1;
                    rd_ptr_next = rd_ptr + ptr_t'(1);
                    if (mem_last[rd_idx]) begin
                        read_last    = 1'b1;
                        r_state_next = R_IDLE;
                    end
                end
            end

            default: begin
                r_state_next = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // Register both FSMs and all four pointers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            wr_ptr     <= '0;
            frm_start  <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            w_state    <= w_state_next;
            r_state    <= r_state_next;
            wr_ptr     <= wr_ptr_next;
            frm_start  <= frm_start_next;
            commit_ptr <= commit_ptr_next;
            rd_ptr     <= rd_ptr_next;
        end
    end

    // Store each accepted word, and mark the end of a frame closed by a bare end strobe.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; the pointers alone decide which entries are meaningful.
        if (mem_we) begin
            mem_data[wr_idx] <= in_data;
            mem_keep[wr_idx] <= in_keep;
            mem_last[wr_idx] <= in_last;
        end
        if (set_last) begin
            mem_last[prev_idx] <= 1'b1;
        end
    end

    // Count committed frames not yet fully sent; a commit and a final read together cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_pending <= '0;
        end else begin
            unique case ({commit, read_last})
                2'b10:   frames_pending <= frames_pending + ptr_t'(1);
                2'b01:   frames_pending <= frames_pending - ptr_t'(1);
                default: frames_pending <= frames_pending;
            endcase
        end
    end

    // Record dropped frames in a sticky flag and a counter that saturates at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX outputs
    // ------------------------------------------------------------------
    // Present the entry at the read pointer while sending, and all zeros otherwise.
    always_comb begin
        m_tvalid = send_active;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        if (send_active) begin
            m_tdata = mem_data[rd_idx];
            m_tkeep = mem_keep[rd_idx];
            m_tlast = mem_last[rd_idx];
        end
    end

    // handshake is a debug-visible decode; tie it into nothing else on purpose.
    logic unused_handshake;
    assign unused_handshake = handshake;

endmodule

// File: tb/tb_aurora_tx_frame_buffer.sv
// Directed testbench for aurora_tx_frame_buffer (ADDR_W = 4, 16 entries).
// A cycle table covers basic frames, bare end strobes and backpressure.
// Hand-written sequences cover overflow, link gating and reset mid-operation.

module tb_aurora_tx_frame_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [3:0]  in_keep;
    logic        channel_up;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic        m_tready;
    logic [4:0]  frames_pending;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aurora_tx_frame_buffer #(.ADDR_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_keep        (in_keep),
        .channel_up     (channel_up),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tkeep        (m_tkeep),
        .m_tready       (m_tready),
        .frames_pending (frames_pending),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    // One cycle of stimulus and the outputs expected after that edge.
    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] d;
        logic [3:0]  k;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic [3:0]  e_keep;
        logic [4:0]  e_fp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic l, input logic [31:0] d,
                                input logic [3:0] k, input logic rdy,
                                input logic ev, input logic [31:0] ed, input logic el,
                                input logic [3:0] ek, input logic [4:0] efp);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.k = k; r.rdy = rdy;
        r.e_valid = ev; r.e_data = ed; r.e_last = el; r.e_keep = ek; r.e_fp = efp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [31:0] ed,
                             input logic el, input logic [3:0] ek, input logic [4:0] efp);
        check({tag, ".tvalid"}, 32'(m_tvalid), 32'(ev));
        check({tag, ".tdata"},  m_tdata,       ed);
        check({tag, ".tlast"},  32'(m_tlast),  32'(el));
        check({tag, ".tkeep"},  32'(m_tkeep),  32'(ek));
        check({tag, ".fp"},     32'(frames_pending), 32'(efp));
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic [3:0] k);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        in_keep  = k;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 32'h0, 4'h0);
    endtask

    // Hard stop if anything ever stalls the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;

        // ---------------- reset ----------------
        reset      = 1'b1;
        channel_up = 1'b1;
        m_tready   = 1'b1;
        idle();
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        check("reset.overflow", 32'(overflow), 32'h0);
        check("reset.drop_count", 32'(drop_count), 32'h0);
        reset = 1'b0;

        // ---------------- cycle table ----------------
        // Basic 3-word frame with m_tready high.
        vecs.push_back(mk(1, 0, 32'h11, 4'hF, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(1, 0, 32'h22, 4'hF, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(1, 1, 32'h33, 4'hF, 1,  0, 32'h0,  0, 4'h0, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'h11, 0, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'h22, 0, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'h33, 1, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        // Frame closed by a bare end strobe; mixed keep values.
        vecs.push_back(mk(1, 0, 32'hA1, 4'h3, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(1, 0, 32'hA2, 4'hC, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(0, 1, 32'h0,  4'h0, 1,  0, 32'h0,  0, 4'h0, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'hA1, 0, 4'h3, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'hA2, 1, 4'hC, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        // Lone end strobe while idle: empty frame, nothing happens.
        vecs.push_back(mk(0, 1, 32'h0,  4'h0, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  0, 32'h0,  0, 4'h0, 5'd0));
        // Backpressure: m_tready toggles, each word held until accepted.
        vecs.push_back(mk(1, 0, 32'hB1, 4'hF, 0,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(1, 0, 32'hB2, 4'hF, 0,  0, 32'h0,  0, 4'h0, 5'd0));
        vecs.push_back(mk(1, 1, 32'hB3, 4'hF, 0,  0, 32'h0,  0, 4'h0, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 0,  1, 32'hB1, 0, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'hB2, 0, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 0,  1, 32'hB2, 0, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  1, 32'hB3, 1, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 0,  1, 32'hB3, 1, 4'hF, 5'd1));
        vecs.push_back(mk(0, 0, 32'h0,  4'h0, 1,  0, 32'h0,  0, 4'h0, 5'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].k);
            m_tready = vecs[i].rdy;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                      vecs[i].e_last, vecs[i].e_keep, vecs[i].e_fp);
        end
        idle();
        m_tready = 1'b1;

        // ---------------- overflow ----------------
        m_tready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            for (int w = 0; w < 3; w++) begin
                drive(1'b1, (w == 2), 32'h100 + 32'(f * 3 + w), 4'hF);
                tick();
            end
        end
        idle();
        check("ovf.fp_after_5", 32'(frames_pending), 32'd5);
        check("ovf.flag_before", 32'(overflow), 32'h0);
        // Sixth frame: first word takes the last free entry, second word drops it.
        drive(1'b1, 1'b0, 32'h200, 4'hF);
        tick();
        check("ovf.flag_first_word", 32'(overflow), 32'h0);
        drive(1'b1, 1'b0, 32'h201, 4'hF);
        tick();
        check("ovf.flag", 32'(overflow), 32'h1);
        check("ovf.drop_count", 32'(drop_count), 32'd1);
        drive(1'b1, 1'b1, 32'h202, 4'hF);
        tick();
        idle();
        tick();
        check("ovf.fp_after_drop", 32'(frames_pending), 32'd5);
        check("ovf.drop_count_held", 32'(drop_count), 32'd1);
        check("ovf.stalled_valid", 32'(m_tvalid), 32'h1);
        check("ovf.stalled_data", m_tdata, 32'h100);
        // Drain: exactly the 15 committed words, in order.
        m_tready = 1'b1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_tvalid) begin
                check($sformatf("ovf.drain%0d", got), m_tdata, 32'h100 + 32'(got));
                got++;
            end
            tick();
        end
        check("ovf.drain_count", 32'(got), 32'd15);
        check("ovf.drained_valid", 32'(m_tvalid), 32'h0);
        check("ovf.drained_fp", 32'(frames_pending), 32'd0);
        check("ovf.flag_sticky", 32'(overflow), 32'h1);

        // ---------------- link gating ----------------
        channel_up = 1'b0;
        m_tready   = 1'b1;
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, (w == 2), 32'h300 + 32'(w), 4'hF);
            tick();
        end
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out($sformatf("link_down%0d", c), 1'b0, 32'h0, 1'b0, 4'h0, 5'd1);
        end
        channel_up = 1'b1;
        m_tready   = 1'b0;
        tick();
        check_out("link_up.w0", 1'b1, 32'h300, 1'b0, 4'hF, 5'd1);
        // Link drops as the first word is accepted; the frame still completes.
        m_tready   = 1'b1;
        channel_up = 1'b0;
        tick();
        check_out("link_drop.w1", 1'b1, 32'h301, 1'b0, 4'hF, 5'd1);
        tick();
        check_out("link_drop.w2", 1'b1, 32'h302, 1'b1, 4'hF, 5'd1);
        tick();
        check_out("link_drop.done", 1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        tick();
        check_out("link_drop.idle", 1'b0, 32'h0, 1'b0, 4'h0, 5'd0);

        // ---------------- reset mid-operation ----------------
        channel_up = 1'b1;
        m_tready   = 1'b0;
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, (w == 2), 32'h400 + 32'(w), 4'hF);
            tick();
        end
        idle();
        tick();
        check_out("pre_reset.send", 1'b1, 32'h400, 1'b0, 4'hF, 5'd1);
        drive(1'b1, 1'b0, 32'h500, 4'hF);
        tick();
        idle();
        reset = 1'b1;
        tick();
        check_out("mid_reset", 1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        check("mid_reset.overflow", 32'(overflow), 32'h0);
        check("mid_reset.drop_count", 32'(drop_count), 32'h0);
        reset    = 1'b0;
        m_tready = 1'b1;
        drive(1'b1, 1'b0, 32'h600, 4'h7);
        tick();
        drive(1'b1, 1'b1, 32'h601, 4'h7);
        tick();
        idle();
        check_out("fresh.commit", 1'b0, 32'h0, 1'b0, 4'h0, 5'd1);
        tick();
        check_out("fresh.w0", 1'b1, 32'h600, 1'b0, 4'h7, 5'd1);
        tick();
        check_out("fresh.w1", 1'b1, 32'h601, 1'b1, 4'h7, 5'd1);
        tick();
        check_out("fresh.done", 1'b0, 32'h0, 1'b0, 4'h0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aurora_tx_frame_buffer.md
# aurora_tx_frame_buffer

Store-and-forward frame buffer between the 3-word readout framer and the Aurora TX user interface. It accepts 32-bit words with valid/last/keep, where the source has no backpressure and may emit a last strobe with valid low. It commits only complete frames, then replays each one as an AXI4-Stream burst gated by `m_tready` and `channel_up`. Frames that cannot fit are dropped whole, and the drop is reported.

## Interface
Parameters:
- `ADDR_W`, default 4, log2 of buffer depth; DEPTH = 2^ADDR_W words.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_data` in 32: upstream word.
- `in_valid` in 1: upstream word valid; no ready path.
- `in_last` in 1: end-of-frame strobe; may be high with `in_valid` low.
- `in_keep` in 4: byte enables, stored per word.
- `channel_up` in 1: Aurora link up.
- `m_tdata` out 32: TX data.
- `m_tvalid` out 1: TX valid.
- `m_tlast` out 1: TX end of frame.
- `m_tkeep` out 4: TX byte enables.
- `m_tready` in 1: TX ready.
- `frames_pending` out ADDR_W+1: count of committed frames not yet fully sent.
- `overflow` out 1: sticky; set on any dropped frame.
- `drop_count` out 8: count of dropped frames, saturating at 255.

## Operation
- **Storage:**
  - Register array of DEPTH entries, each holding {data, keep, last}.
  - Pointers `wr_ptr`, `frm_start`, `commit_ptr` and `rd_ptr` are ADDR_W+1 bits wide and wrap modulo 2^(ADDR_W+1).
  - occupancy = `wr_ptr` − `rd_ptr`; full when occupancy == DEPTH.
- **Write FSM (W_IDLE, W_FILL, W_DROP):**
  - W_IDLE/W_FILL, `in_valid`=1, not full: write the entry at `wr_ptr`, increment `wr_ptr`, enter W_FILL. The last bit is written as `in_last`.
  - W_IDLE/W_FILL, `in_valid`=1, full: drop the frame.
    - `wr_ptr` ← `frm_start`, `overflow` ← 1, `drop_count` +1 (saturating).
    - If `in_last`=1, go to W_IDLE; otherwise go to W_DROP.
  - W_DROP: discard all input until `in_last`=1 (valid or not), then go to W_IDLE.
  - Commit on `in_last` with `in_valid`=1 (word written): `commit_ptr` ← `frm_start` ← `wr_ptr`+1, `frames_pending` +1, go to W_IDLE.
  - Commit on `in_last` with `in_valid`=0 in W_FILL:
    - Set the last bit of entry `wr_ptr`−1.
    - `commit_ptr` ← `frm_start` ← `wr_ptr`, `frames_pending` +1, go to W_IDLE.
  - `in_last`=1 with `in_valid`=0 in W_IDLE: empty frame, ignored and not counted.
  - `in_valid`=0 with `in_last`=0: ignored in every state.
  - A frame longer than DEPTH words can never be committed and is always dropped.
- **Read FSM (R_IDLE, R_SEND):**
  - R_IDLE → R_SEND when `channel_up`=1 and `rd_ptr` != `commit_ptr`.
  - In R_SEND, `m_tvalid`=1 and the outputs show the entry at `rd_ptr`.
  - On `m_tvalid` && `m_tready`: increment `rd_ptr`. If the accepted entry's last bit is set, decrement `frames_pending` and return to R_IDLE.
  - `channel_up` is sampled only in R_IDLE. A frame already started completes even if the link drops.
  - While in R_SEND, `m_tvalid` never deasserts before the accepting handshake.
- **Output gating:** `m_tdata`, `m_tkeep` and `m_tlast` are forced to 0 whenever `m_tvalid`=0.
- **Simultaneous events:**
  - Full is evaluated on pre-edge pointers, so a read in the same cycle does not admit a write.
  - A commit and a last-word read in the same cycle leave `frames_pending` unchanged.
  - `frames_pending` maximum is DEPTH; it cannot overflow.

## Timing
- **Reset:**
  - All pointers 0, both FSMs idle.
  - `m_tvalid`, `m_tlast`, `m_tdata`, `m_tkeep` all 0.
  - `frames_pending`=0, `overflow`=0, `drop_count`=0.
  - Buffer contents are not cleared.
  - Reset mid-frame discards all buffered and partial data. An in-flight TX frame is truncated without `m_tlast`.
- **Latency:**
  - Commit edge N to the first `m_tvalid` cycle is 1 cycle (R_IDLE evaluates at edge N+1) when `channel_up`=1.
  - Minimum input-to-output latency is 2 cycles from the last input word.
- **Throughput:** one word per cycle while `m_tready`=1. There is one idle cycle between consecutive frames (R_IDLE).

## Test plan
- **Basic frame, `m_tready`=1, `channel_up`=1:** words 0x11, 0x22, 0x33 (keep F, last on 0x33) → `m_tvalid` rises 1 cycle after commit; 0x11, 0x22, 0x33 are sent on consecutive cycles, `m_tlast` only with 0x33, `m_tkeep`=F; `frames_pending` goes 1 → 0.
- **Terminating last with valid low:** 0xA1 valid, 0xA2 valid, then `in_last`=1 with `in_valid`=0 → 2-word frame with `m_tlast` on 0xA2. A lone `in_last` with valid low in W_IDLE → no output, `frames_pending` stays 0.
- **Overflow, `ADDR_W`=4, `m_tready`=0:**
  - Push five 3-word frames → `frames_pending`=5, occupancy 15.
  - Push a sixth frame → its first word fills entry 16, its second word triggers a drop → `overflow`=1, `drop_count`=1, `frames_pending`=5.
  - Raise `m_tready` → exactly 15 words drain, then `m_tvalid`=0.
- **Backpressure:** toggle `m_tready` 1010… during a 3-word frame → each word is held stable until accepted; no duplicated or skipped words.
- **Link gating:**
  - `channel_up`=0 with 1 frame committed → `m_tvalid` stays 0; raising `channel_up` → frame sent.
  - Drop `channel_up` after the first word is accepted → remaining 2 words still sent with `m_tlast`.
- **Reset mid-operation:** assert `reset` while in W_FILL and R_SEND → next cycle all outputs 0, `frames_pending`=0, `overflow`=0, `drop_count`=0. A fresh frame afterwards passes cleanly.
